mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle sequencer for the MIPS datapath: PC, instruction memory/IR, register file, ALU control/ALU, data memory and the three datapath muxes. It replaces the single-cycle opcode decoder with an FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It emits per-state strobes and mux selects. It stalls on a shared memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter
ILLEGAL_HALT, 1, 1: illegal opcode enters HALT; 0: illegal opcode treated as NOP (back to FETCH)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], valid from the DECODE cycle onward
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes the current read/write this cycle
PCWrite  out  1  PC load strobe
PCSrc  out  1  0: PC+4; 1: branch target
IRWrite  out  1  IR load strobe
RegDst  out  1  0: rt; 1: rd
ALUSrc  out  1  0: ReadData2; 1: sign-extended immediate
ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
MemRead  out  1  memory read request (fetch or load)
MemWrite  out  1  data memory write request
MemtoReg  out  1  0: ALUOut; 1: memory data
RegWrite  out  1  register-file write strobe
State  out  3  current state encoding
Illegal  out  1  sticky; set on unsupported opcode
InstrCount  out  CNT_W  retired instructions

Behaviour:
- Reset (RESET_N=0, async): state=FETCH, latched opcode=0, Illegal=0, InstrCount=0. All strobes are 0 while RESET_N=0, including the FETCH MemRead.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Outputs are combinational from the state register and the latched opcode (Moore). The exception is IRWrite/PCWrite in FETCH and PCWrite in EXEC, which are gated as described below. Every unlisted output is 0.
- FETCH: MemRead=1, ALUOp=00, PCSrc=0. When MemReady=1: IRWrite=1, PCWrite=1, next state DECODE. Otherwise hold FETCH with no strobes.
- DECODE: latch opcode (1 cycle).
  - Supported opcodes: 0 (R-type), 35 (lw), 43 (sw), 8 (addi) go to EXEC.
  - Any other opcode sets Illegal. Next state is HALT if ILLEGAL_HALT=1, else FETCH without incrementing InstrCount.
- EXEC:
  - R-type: ALUSrc=0, ALUOp=10, next WB.
  - lw/sw: ALUSrc=1, ALUOp=00, next MEM.
  - addi: ALUSrc=1, ALUOp=00, next WB.
- MEM:
  - lw: MemRead=1, ALUSrc=1; advance to WB when MemReady=1.
  - sw: MemWrite=1 held until MemReady=1, then FETCH and retire.
- WB: RegWrite=1 for exactly one cycle, then FETCH and retire.
  - R-type: RegDst=1, MemtoReg=0.
  - lw: MemtoReg=1.
  - addi: RegDst=0, MemtoReg=0.
- Latency with MemReady tied to 1: R/addi 4 cycles, sw 4, lw 5. Each wait cycle with MemReady=0 adds 1 cycle.
- Retire: InstrCount increments by 1 on each transition into FETCH from WB, MEM (sw) or EXEC (beq). It wraps from all-ones to 0.
- HALT: terminal; all strobes 0; exits only via reset.
- MemReady while not in FETCH/MEM is ignored.
- Reset mid-instruction aborts immediately. No partial RegWrite/MemWrite occurs after RESET_N falls.
- MemRead and MemWrite are never both 1. RegWrite and IRWrite are never both 1.

Optional Feature:
Macro MIPS_CTRL_BEQ_EN.
- Defined: opcode 4 (beq) is supported. DECODE goes to EXEC. EXEC drives ALUSrc=0, ALUOp=01, PCSrc=1, PCWrite=Zero, then FETCH and retire (3 cycles).
- Undefined: opcode 4 is illegal, handled per ILLEGAL_HALT.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE=0, OP_BEQ=4, OP_ADDI=8, OP_LW=35, OP_SW=43
  - state encoding constants
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - packed control-word typedef (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, PCSrc, ALUOp)
- Sub-module mips_ctrl_decode: purely combinational (state, opcode, Zero, MemReady) -> control word. The top module holds the state register, opcode latch, Illegal flag and counter.

Test Plan:
- R-type add, MemReady=1 constant, reset released at t0 -> States 0,1,2,4,0. RegWrite=1 with RegDst=1 only in cycle 4. InstrCount=1.
- lw, MemReady low for 2 cycles in MEM -> MEM held 3 cycles with MemRead=1. WB has MemtoReg=1, RegWrite=1. Total 7 cycles. InstrCount+1.
- sw, MemReady low 1 cycle in FETCH -> FETCH held 2 cycles, IRWrite pulses once. MemWrite=1 only in MEM. RegWrite never asserted.
- opcode=6'd2 with ILLEGAL_HALT=1 -> Illegal=1, State=5 persists 20 cycles, all strobes 0. RESET_N pulse returns State=0, Illegal=0.
- BEQ_EN defined, opcode 4: Zero=1 -> EXEC PCSrc=1, PCWrite=1. Zero=0 -> PCWrite=0. Both take 3 cycles. Undefined -> Illegal=1.
- RESET_N asserted during WB of addi -> RegWrite drops to 0 asynchronously. State=0, InstrCount=0 after release. With CNT_W=4, 16 retires -> InstrCount wraps to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
// Optional beq support is enabled with MIPS_CTRL_BEQ_EN.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       pc_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_supported(
    input logic [5:0] op
  );
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) ||
         (op == OP_SW) || (op == OP_ADDI);
`ifdef MIPS_CTRL_BEQ_EN
    ok = ok || (op == OP_BEQ);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_decode.sv
// Combinational control-word decode from state and latched opcode.
// beq control (MIPS_CTRL_BEQ_EN) uses the ALU zero flag.
module mips_multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctl
);

`ifndef MIPS_CTRL_BEQ_EN
  logic unused_zero;
  assign unused_zero = zero;
`endif

  always_comb begin
    ctl = '0;
    unique case (state)
      S_FETCH: begin
        ctl.mem_read = 1'b1;
        ctl.alu_op   = ALUOP_ADD;
        ctl.ir_write = mem_ready;
        ctl.pc_write = mem_ready;
      end
      S_EXEC: begin
        unique case (1'b1)
          (opcode == OP_RTYPE): begin
            ctl.alu_op = ALUOP_FUNCT;
          end
          (opcode == OP_LW),
          (opcode == OP_SW),
          (opcode == OP_ADDI): begin
            ctl.alu_src = 1'b1;
          end
`ifdef MIPS_CTRL_BEQ_EN
          (opcode == OP_BEQ): begin
            ctl.alu_op   = ALUOP_SUB;
            ctl.pc_src   = 1'b1;
            ctl.pc_write = zero;
          end
`endif
          default: ;
        endcase
      end
      S_MEM: begin
        unique case (1'b1)
          (opcode == OP_LW): begin
            ctl.mem_read = 1'b1;
            ctl.alu_src  = 1'b1;
          end
          (opcode == OP_SW): begin
            ctl.mem_write = 1'b1;
          end
          default: ;
        endcase
      end
      S_WB: begin
        ctl.reg_write = 1'b1;
        unique case (1'b1)
          (opcode == OP_RTYPE): ctl.reg_dst = 1'b1;
          (opcode == OP_LW):    ctl.mem_to_reg = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: state, opcode latch, sticky illegal, retire count.
// Define MIPS_CTRL_BEQ_EN to support beq (opcode 4).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [5:0]       opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [2:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  state_e           state;
  logic [5:0]       op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt;
  ctrl_t            cw;
  ctrl_t            cw_g;

  mips_multicycle_ctrl_decode u_dec (
    .state     (state),
    .opcode    (op_q),
    .zero      (Zero),
    .mem_ready (MemReady),
    .ctl       (cw)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (MemReady) state <= S_DECODE;
        end
        S_DECODE: begin
          op_q <= opcode;
          if (op_supported(opcode)) begin
            state <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state     <= ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            (op_q == OP_RTYPE),
            (op_q == OP_ADDI): state <= S_WB;
            (op_q == OP_LW),
            (op_q == OP_SW):   state <= S_MEM;
`ifdef MIPS_CTRL_BEQ_EN
            (op_q == OP_BEQ): begin
              state <= S_FETCH;
              cnt   <= cnt + CNT_W'(1);
            end
`endif
            default: state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (MemReady) begin
            if (op_q == OP_SW) begin
              state <= S_FETCH;
              cnt   <= cnt + CNT_W'(1);
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          state <= S_FETCH;
          cnt   <= cnt + CNT_W'(1);
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Reset forces every strobe low at once, aborting any write in flight.
  assign cw_g = RESET_N ? cw : '0;

  assign PCWrite    = cw_g.pc_write;
  assign PCSrc      = cw_g.pc_src;
  assign IRWrite    = cw_g.ir_write;
  assign RegDst     = cw_g.reg_dst;
  assign ALUSrc     = cw_g.alu_src;
  assign ALUOp      = cw_g.alu_op;
  assign MemRead    = cw_g.mem_read;
  assign MemWrite   = cw_g.mem_write;
  assign MemtoReg   = cw_g.mem_to_reg;
  assign RegWrite   = cw_g.reg_write;
  assign State      = state;
  assign Illegal    = illegal_q;
  assign InstrCount = cnt;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl (CNT_W=4, ILLEGAL_HALT=1).
// Control bits: {PCWrite,PCSrc,IRWrite,RegDst,ALUSrc,ALUOp,MemRead,MemWrite,MemtoReg,RegWrite}.
module tb_mips_multicycle_ctrl;

  localparam logic [10:0] C_NONE  = 11'b0_0_0_0_0_00_0_0_0_0;
  localparam logic [10:0] C_F_RDY = 11'b1_0_1_0_0_00_1_0_0_0;
  localparam logic [10:0] C_F_WT  = 11'b0_0_0_0_0_00_1_0_0_0;
  localparam logic [10:0] C_EX_R  = 11'b0_0_0_0_0_10_0_0_0_0;
  localparam logic [10:0] C_EX_I  = 11'b0_0_0_0_1_00_0_0_0_0;
  localparam logic [10:0] C_MEM_L = 11'b0_0_0_0_1_00_1_0_0_0;
  localparam logic [10:0] C_MEM_S = 11'b0_0_0_0_0_00_0_1_0_0;
  localparam logic [10:0] C_WB_R  = 11'b0_0_0_1_0_00_0_0_0_1;
  localparam logic [10:0] C_WB_L  = 11'b0_0_0_0_0_00_0_0_1_1;
  localparam logic [10:0] C_WB_A  = 11'b0_0_0_0_0_00_0_0_0_1;
  localparam logic [10:0] C_BQ_Z1 = 11'b1_1_0_0_0_01_0_0_0_0;
  localparam logic [10:0] C_BQ_Z0 = 11'b0_1_0_0_0_01_0_0_0_0;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [5:0] opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCSrc, IRWrite, RegDst, ALUSrc;
  logic [1:0] ALUOp;
  logic       MemRead, MemWrite, MemtoReg, RegWrite;
  logic [2:0] State;
  logic       Illegal;
  logic [3:0] InstrCount;
  logic [10:0] ctl;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  assign ctl = {PCWrite, PCSrc, IRWrite, RegDst, ALUSrc,
                ALUOp, MemRead, MemWrite, MemtoReg, RegWrite};

  mips_multicycle_ctrl #(
    .CNT_W        (4),
    .ILLEGAL_HALT (1'b1)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .opcode     (opcode),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .ALUSrc     (ALUSrc),
    .ALUOp      (ALUOp),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .State      (State),
    .Illegal    (Illegal),
    .InstrCount (InstrCount)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check state/controls, advance past the edge.
  task automatic cyc(input string tag, input logic rdy,
                     input logic z, input logic [2:0] st,
                     input logic [10:0] c);
    MemReady = rdy;
    Zero     = z;
    #1;
    check({tag, ".state"}, 32'(State), 32'(st));
    check({tag, ".ctl"}, 32'(ctl), 32'(c));
    @(posedge CLK);
    #1;
  endtask

  // Reset held across one edge; outputs checked while it is low.
  task automatic rst_pulse(input string tag);
    RESET_N = 1'b0;
    #1;
    check({tag, ".rst_state"}, 32'(State), 32'd0);
    check({tag, ".rst_ctl"}, 32'(ctl), 32'd0);
    check({tag, ".rst_ill"}, 32'(Illegal), 32'd0);
    check({tag, ".rst_cnt"}, 32'(InstrCount), 32'd0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic run_r(input string tag);
    opcode = 6'd0;
    cyc({tag, ".F"}, 1'b1, 1'b0, 3'd0, C_F_RDY);
    cyc({tag, ".D"}, 1'b1, 1'b0, 3'd1, C_NONE);
    cyc({tag, ".E"}, 1'b1, 1'b0, 3'd2, C_EX_R);
    cyc({tag, ".W"}, 1'b1, 1'b0, 3'd4, C_WB_R);
  endtask

  initial begin
    RESET_N  = 1'b0;
    MemReady = 1'b1;
    Zero     = 1'b0;
    opcode   = 6'd0;
    #12;
    check("reset.state", 32'(State), 32'd0);
    check("reset.ctl", 32'(ctl), 32'd0);
    check("reset.ill", 32'(Illegal), 32'd0);
    check("reset.cnt", 32'(InstrCount), 32'd0);
    RESET_N = 1'b1;

    run_r("rtype");
    check("rtype.cnt", 32'(InstrCount), 32'd1);

    opcode = 6'd35;
    cyc("lw.F", 1'b1, 1'b0, 3'd0, C_F_RDY);
    cyc("lw.D", 1'b1, 1'b0, 3'd1, C_NONE);
    cyc("lw.E", 1'b1, 1'b0, 3'd2, C_EX_I);
    cyc("lw.M0", 1'b0, 1'b0, 3'd3, C_MEM_L);
    cyc("lw.M1", 1'b0, 1'b0, 3'd3, C_MEM_L);
    cyc("lw.M2", 1'b1, 1'b0, 3'd3, C_MEM_L);
    cyc("lw.W", 1'b1, 1'b0, 3'd4, C_WB_L);
    check("lw.cnt", 32'(InstrCount), 32'd2);

    opcode = 6'd43;
    cyc("sw.F0", 1'b0, 1'b0, 3'd0, C_F_WT);
    cyc("sw.F1", 1'b1, 1'b0, 3'd0, C_F_RDY);
    cyc("sw.D", 1'b0, 1'b0, 3'd1, C_NONE);
    cyc("sw.E", 1'b0, 1'b0, 3'd2, C_EX_I);
    cyc("sw.M", 1'b1, 1'b0, 3'd3, C_MEM_S);
    check("sw.state", 32'(State), 32'd0);
    check("sw.cnt", 32'(InstrCount), 32'd3);

    opcode = 6'd8;
    cyc("addi.F", 1'b1, 1'b0, 3'd0, C_F_RDY);
    cyc("addi.D", 1'b1, 1'b0, 3'd1, C_NONE);
    cyc("addi.E", 1'b1, 1'b0, 3'd2, C_EX_I);
    cyc("addi.W", 1'b1, 1'b0, 3'd4, C_WB_A);
    check("addi.cnt", 32'(InstrCount), 32'd4);

    cyc("addi2.F", 1'b1, 1'b0, 3'd0, C_F_RDY);
    cyc("addi2.D", 1'b1, 1'b0, 3'd1, C_NONE);
    cyc("addi2.E", 1'b1, 1'b0, 3'd2, C_EX_I);
    #1;
    check("addi2.W.state", 32'(State), 32'd4);
    check("addi2.W.regwr", 32'(RegWrite), 32'd1);
    rst_pulse("addi2");
    check("addi2.post_cnt", 32'(InstrCount), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_r($sformatf("wrap%0d", i));
      if (i == 14) check("wrap.cnt15", 32'(InstrCount), 32'd15);
    end
    check("wrap.cnt0", 32'(InstrCount), 32'd0);

    opcode = 6'd4;
`ifdef MIPS_CTRL_BEQ_EN
    cyc("beq1.F", 1'b1, 1'b1, 3'd0, C_F_RDY);
    cyc("beq1.D", 1'b1, 1'b1, 3'd1, C_NONE);
    cyc("beq1.E", 1'b1, 1'b1, 3'd2, C_BQ_Z1);
    check("beq1.cnt", 32'(InstrCount), 32'd1);
    cyc("beq0.F", 1'b1, 1'b0, 3'd0, C_F_RDY);
    cyc("beq0.D", 1'b1, 1'b0, 3'd1, C_NONE);
    cyc("beq0.E", 1'b1, 1'b0, 3'd2, C_BQ_Z0);
    check("beq0.state", 32'(State), 32'd0);
    check("beq0.cnt", 32'(InstrCount), 32'd2);
    check("beq.ill", 32'(Illegal), 32'd0);
`else
    cyc("beq.F", 1'b1, 1'b1, 3'd0, C_F_RDY);
    cyc("beq.D", 1'b1, 1'b1, 3'd1, C_NONE);
    cyc("beq.H", 1'b1, 1'b1, 3'd5, C_NONE);
    check("beq.ill", 32'(Illegal), 32'd1);
    check("beq.cnt", 32'(InstrCount), 32'd0);
    rst_pulse("beq");
`endif

    opcode = 6'd2;
    cyc("ill.F", 1'b1, 1'b0, 3'd0, C_F_RDY);
    cyc("ill.D", 1'b1, 1'b0, 3'd1, C_NONE);
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("halt%0d", i), i[0], 1'b0, 3'd5, C_NONE);
      check($sformatf("halt%0d.ill", i), 32'(Illegal), 32'd1);
    end
    rst_pulse("ill");
    opcode = 6'd0;
    cyc("post.F", 1'b1, 1'b0, 3'd0, C_F_RDY);
    check("post.ill", 32'(Illegal), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
